// File: rtl/rv32_fetch_pkg.sv
// rv32_fetch_pkg: shared constants and types for the rv32 instruction fetch stage.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (adds the S_FAULT state for misaligned redirect targets).
package rv32_fetch_pkg;

    localparam int          API_DATA_WIDTH    = 32;
    localparam int          FETCH_STATE_WIDTH = 3;
    localparam logic [31:0] INST_NOP          = 32'h0000_0013;

    // One buffered instruction: {pc, instr, fault} packed MSB first
    localparam int ENTRY_W = 32 + API_DATA_WIDTH + 1;

    typedef enum logic [FETCH_STATE_WIDTH-1:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_FLUSH = 3'd3
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        S_FAULT = 3'd4
`endif
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]               pc;
        logic [API_DATA_WIDTH-1:0] instr;
        logic                      fault;
    } fetch_entry_t;

    // Sequential word address; wraps from FFFF_FFFC back to 0
    function automatic logic [31:0] next_word_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/rv32_fetch_fifo.sv
// rv32_fetch_fifo: small circular buffer of fetched instructions with their PC and fault marker.
// clear empties the buffer and wins over push/pop in the same cycle. The head is visible combinationally.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (no effect here; fault bits are simply stored).
module rv32_fetch_fifo
    import rv32_fetch_pkg::*;
#(
    parameter  int BUF_DEPTH = 2,
    localparam int PTR_W     = $clog2(BUF_DEPTH),
    localparam int CNT_W     = $clog2(BUF_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               clear,
    input  logic [ENTRY_W-1:0] push_data,
    output logic [CNT_W-1:0]   count,
    output logic               empty,
    output logic [ENTRY_W-1:0] head
);

    logic [ENTRY_W-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // Storage write; the payload needs no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push && !clear && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/rv32_fetch_unit.sv
// rv32_fetch_unit: fetch stage holding the PC, issuing one imem request at a time and buffering
// returned words for the decoder. A redirect flushes the buffer and any in-flight response.
// Optional feature macro: FETCH_MISALIGN_CHK_EN. When defined, a redirect to a non-word-aligned
// target fetches nothing and instead delivers one NOP entry flagged as faulting, then parks in
// S_FAULT until the next redirect. When undefined, the low two target bits are ignored.
module rv32_fetch_unit
    import rv32_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req_o,
    output logic [31:0]               imem_addr_o,
    input  logic                      imem_gnt_i,
    input  logic                      imem_rvalid_i,
    input  logic [31:0]               imem_rdata_i,
    input  logic                      redirect_i,
    input  logic [31:0]               redirect_pc_i,
    output logic                      instr_valid_o,
    input  logic                      instr_ready_i,
    output logic [API_DATA_WIDTH-1:0] instruction_o,
    output logic [31:0]               pc_o,
    output logic                      instr_fault_o
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_t       state;
    fetch_state_t       state_next;
    logic [31:0]        fetch_pc;
    logic [31:0]        fetch_pc_next;
    logic [31:0]        redirect_target;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               empty;
    logic               grant;
    logic               push;
    logic               pop;
    logic               clear;
    logic               req_next;
    fetch_entry_t       push_entry;
    fetch_entry_t       head_entry;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head_data;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misaligned;
    logic fault_pending;
    logic fault_pending_next;

    assign redirect_target = redirect_pc_i;
    assign misaligned      = (redirect_pc_i[1:0] != 2'b00);
`else
    logic [1:0] unused_redirect_lsbs;

    assign redirect_target      = {redirect_pc_i[31:2], 2'b00};
    assign unused_redirect_lsbs = redirect_pc_i[1:0];
`endif

    // A request only counts as accepted when we were actually asking
    assign grant       = imem_req_o && imem_gnt_i;
    assign imem_addr_o = fetch_pc;
    assign push_data   = push_entry;
    assign head_entry  = head_data;

    rv32_fetch_fifo #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clear     (clear),
        .push_data (push_data),
        .count     (count),
        .empty     (empty),
        .head      (head_data)
    );

    // Next-state, PC and buffer control; a redirect overrides every other action this cycle
    always_comb begin
        state_next       = state;
        fetch_pc_next    = fetch_pc;
        push             = 1'b0;
        pop              = !empty && instr_ready_i;
        clear            = 1'b0;
        push_entry.pc    = fetch_pc - 32'd4;
        push_entry.instr = imem_rdata_i;
        push_entry.fault = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        fault_pending_next = fault_pending;
`endif
        if (redirect_i) begin
            clear         = 1'b1;
            pop           = 1'b0;
            fetch_pc_next = redirect_target;
            if ((state == S_WAIT && !imem_rvalid_i) || (state == S_REQ && grant)) begin
                state_next = S_FLUSH;
            end else if (state == S_FLUSH && !imem_rvalid_i) begin
                state_next = S_FLUSH;
            end else begin
`ifdef FETCH_MISALIGN_CHK_EN
                state_next = misaligned ? S_FAULT : S_REQ;
`else
                state_next = S_REQ;
`endif
            end
`ifdef FETCH_MISALIGN_CHK_EN
            fault_pending_next = misaligned;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    state_next = S_REQ;
                end
                S_REQ: begin
                    if (grant) begin
                        fetch_pc_next = next_word_pc(fetch_pc);
                        state_next    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        push       = 1'b1;
                        state_next = S_REQ;
                    end
                end
                S_FLUSH: begin
                    if (imem_rvalid_i) begin
`ifdef FETCH_MISALIGN_CHK_EN
                        state_next = fault_pending ? S_FAULT : S_REQ;
`else
                        state_next = S_REQ;
`endif
                    end
                end
`ifdef FETCH_MISALIGN_CHK_EN
                S_FAULT: begin
                    if (fault_pending) begin
                        push               = 1'b1;
                        push_entry.pc      = fetch_pc;
                        push_entry.instr   = INST_NOP;
                        push_entry.fault   = 1'b1;
                        fault_pending_next = 1'b0;
                    end
                end
`endif
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
        count_next = clear ? '0 : (count + CNT_W'(push) - CNT_W'(pop));
        // A slot is reserved at grant, so S_REQ only needs a non-full buffer
        req_next   = (state_next == S_REQ) && (count_next != CNT_W'(BUF_DEPTH));
    end

    // FSM state, fetch PC and the registered request line
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            fetch_pc   <= RESET_PC;
            imem_req_o <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            fault_pending <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            fetch_pc   <= fetch_pc_next;
            imem_req_o <= req_next;
`ifdef FETCH_MISALIGN_CHK_EN
            fault_pending <= fault_pending_next;
`endif
        end
    end

    assign instr_valid_o = !empty;
    assign instruction_o = empty ? '0 : head_entry.instr;
    assign pc_o          = empty ? 32'h0 : head_entry.pc;

`ifdef FETCH_MISALIGN_CHK_EN
    assign instr_fault_o = !empty && head_entry.fault;
`else
    logic unused_head_fault;

    assign unused_head_fault = head_entry.fault;
    assign instr_fault_o     = 1'b0;
`endif

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// tb_rv32_fetch_unit: scoreboard bench for rv32_fetch_unit with a small instruction memory model.
// Optional feature macro: FETCH_MISALIGN_CHK_EN selects the misaligned-redirect scenario variant.
module tb_rv32_fetch_unit;
    import rv32_fetch_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic        instr_fault_o;

    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb_q[$];
    logic [31:0] gnt_log[$];
    int          grants_allowed = 0;
    int          grant_count = 0;
    int          resp_extra = 0;
    bit          stray_rvalid = 1'b1;

    rv32_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instruction_o (instruction_o),
        .pc_o          (pc_o),
        .instr_fault_o (instr_fault_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Memory contents: distinct word per address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0] ^ 16'h0F0F, a[15:0]};
    endfunction

    function automatic logic [31:0] log_addr(input int idx);
        if (idx < gnt_log.size()) return gnt_log[idx];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] rpc);
        instr_ready_i = ready;
        redirect_i    = redir;
        redirect_pc_i = rpc;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pushExp(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
        exp_t e;
        e.pc = pc;
        e.instr = instr;
        e.fault = fault;
        sb_q.push_back(e);
    endtask

    task automatic pushStream(input logic [31:0] start_pc, input int n);
        logic [31:0] pc;
        pc = start_pc;
        for (int i = 0; i < n; i++) begin
            pushExp(pc, mem_word(pc), 1'b0);
            pc = pc + 32'd4;
        end
        grants_allowed += n;
    endtask

    task automatic drain(input int bound);
        bit done;
        done = 1'b0;
        instr_ready_i = 1'b1;
        for (int i = 0; i < bound && !done; i++) begin
            tick(1);
            if (sb_q.size() == 0 && !instr_valid_o && grant_count == grants_allowed) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain_timeout: got %0d entries pending, expected 0", sb_q.size());
        end
    endtask

    // Memory model: grants within budget, answers 1+resp_extra cycles after the grant
    initial begin
        bit          pend_valid;
        int          pend_cnt;
        logic [31:0] pend_addr;
        pend_valid    = 1'b0;
        pend_cnt      = 0;
        pend_addr     = 32'h0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        forever begin
            @(negedge clk);
            if (pend_valid) checkOutput("req_while_outstanding", {63'h0, imem_req_o}, 64'h0);
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
            if (stray_rvalid) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = 32'hDEAD_BEEF;
            end else if (pend_valid) begin
                if (pend_cnt == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem_word(pend_addr);
                    pend_valid    = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            imem_gnt_i = 1'b0;
            if (!rst && imem_req_o && grant_count < grants_allowed) begin
                imem_gnt_i = 1'b1;
                pend_valid = 1'b1;
                pend_cnt   = resp_extra;
                pend_addr  = imem_addr_o;
                grant_count++;
                gnt_log.push_back(imem_addr_o);
            end
        end
    end

    // Monitor: every accepted instruction is compared with the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && instr_valid_o && instr_ready_i && !redirect_i) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL sb_unexpected: got pc 0x%0h instr 0x%0h, expected no output", pc_o, instruction_o);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("sb_pc", {32'h0, pc_o}, {32'h0, e.pc});
                    checkOutput("sb_instr", {32'h0, instruction_o}, {32'h0, e.instr});
                    checkOutput("sb_fault", {63'h0, instr_fault_o}, {63'h0, e.fault});
                end
            end
        end
    end

    // Directed scenarios
    initial begin
        int  base;
        int  g0;
        bit  found;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        tick(3);

        $display("[TB] reset state");
        checkOutput("rst_req", {63'h0, imem_req_o}, 64'h0);
        checkOutput("rst_addr", {32'h0, imem_addr_o}, 64'h0);
        checkOutput("rst_valid", {63'h0, instr_valid_o}, 64'h0);
        checkOutput("rst_instr", {32'h0, instruction_o}, 64'h0);
        checkOutput("rst_pc", {32'h0, pc_o}, 64'h0);
        checkOutput("rst_fault", {63'h0, instr_fault_o}, 64'h0);

        rst = 1'b0;
        checkOutput("idle_req", {63'h0, imem_req_o}, 64'h0);
        tick(1);
        stray_rvalid = 1'b0;
        checkOutput("first_req", {63'h0, imem_req_o}, 64'h1);
        checkOutput("first_addr", {32'h0, imem_addr_o}, 64'h0);
        checkOutput("idle_rvalid_ignored", {63'h0, instr_valid_o}, 64'h0);

        $display("[TB] streaming fetch");
        base = gnt_log.size();
        instr_ready_i = 1'b1;
        pushStream(32'h0, 6);
        drain(100);
        for (int i = 0; i < 6; i++) checkOutput("t1_addr", {32'h0, log_addr(base + i)}, 64'(4 * i));

        $display("[TB] decoder stall");
        g0 = grant_count;
        instr_ready_i = 1'b0;
        pushStream(32'h18, 10);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (i >= 5) begin
                checkOutput("t2_req_stall", {63'h0, imem_req_o}, 64'h0);
                checkOutput("t2_head_pc", {32'h0, pc_o}, 64'h18);
                checkOutput("t2_head_instr", {32'h0, instruction_o}, {32'h0, mem_word(32'h18)});
            end
        end
        checkOutput("t2_fetched", 64'(grant_count - g0), 64'd2);
        drain(200);

        $display("[TB] redirect during wait");
        resp_extra = 2;
        instr_ready_i = 1'b1;
        grants_allowed += 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1);
            if (imem_gnt_i) found = 1'b1;
        end
        checkOutput("t3_gnt_seen", {63'h0, found}, 64'h1);
        base = gnt_log.size();
        applyStimulus(1'b1, 1'b1, 32'h100);
        resp_extra = 0;
        tick(1);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t3_flush_noreq", {63'h0, imem_req_o}, 64'h0);
        pushStream(32'h100, 3);
        drain(200);
        checkOutput("t3_first_addr", {32'h0, log_addr(base)}, 64'h100);

        $display("[TB] redirect with grant and pop");
        instr_ready_i = 1'b0;
        grants_allowed += 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1);
            if (instr_valid_o) found = 1'b1;
        end
        checkOutput("t4_head_valid", {63'h0, found}, 64'h1);
        checkOutput("t4_req", {63'h0, imem_req_o}, 64'h1);
        base = gnt_log.size();
        grants_allowed += 1;
        applyStimulus(1'b1, 1'b1, 32'h300);
        tick(1);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t4_flushed", {63'h0, instr_valid_o}, 64'h0);
        pushStream(32'h300, 2);
        drain(200);
        checkOutput("t4_gnt_addr", {32'h0, log_addr(base)}, 64'h110);
        checkOutput("t4_resume_addr", {32'h0, log_addr(base + 1)}, 64'h300);

        $display("[TB] address wrap");
        base = gnt_log.size();
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC);
        tick(1);
        applyStimulus(1'b1, 1'b0, 32'h0);
        pushStream(32'hFFFF_FFFC, 2);
        drain(200);
        checkOutput("t5_top_addr", {32'h0, log_addr(base)}, 64'hFFFF_FFFC);
        checkOutput("t5_wrap_addr", {32'h0, log_addr(base + 1)}, 64'h0);

`ifdef FETCH_MISALIGN_CHK_EN
        $display("[TB] misaligned redirect");
        pushExp(32'h102, 32'h13, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h102);
        tick(1);
        applyStimulus(1'b1, 1'b0, 32'h0);
        g0 = grant_count;
        grants_allowed += 2;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (i % 3 == 0) checkOutput("t6_fault_noreq", {63'h0, imem_req_o}, 64'h0);
        end
        checkOutput("t6_no_grant", 64'(grant_count - g0), 64'd0);
        checkOutput("t6_fault_consumed", 64'(sb_q.size()), 64'd0);
        base = gnt_log.size();
        pushExp(32'h200, mem_word(32'h200), 1'b0);
        pushExp(32'h204, mem_word(32'h204), 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h200);
        tick(1);
        applyStimulus(1'b1, 1'b0, 32'h0);
        drain(200);
        checkOutput("t6_resume_addr", {32'h0, log_addr(base)}, 64'h200);
`else
        $display("[TB] misaligned redirect target is word aligned");
        base = gnt_log.size();
        applyStimulus(1'b1, 1'b1, 32'h10A);
        tick(1);
        applyStimulus(1'b1, 1'b0, 32'h0);
        pushStream(32'h108, 2);
        drain(200);
        checkOutput("t6_aligned_addr", {32'h0, log_addr(base)}, 64'h108);
`endif

        checkOutput("sb_empty_end", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
